cpu_seq_ctrl: RTL
=================

# cpu_seq_ctrl

Multi-cycle sequencer for the 8-bit register/ALU datapath. It fetches 32-bit instructions from an instruction memory over a request/ready handshake, decodes the LOADI/ADD/AND/OR/MOV/SUB encoding, and drives the register-file addresses, ALU select, negate and immediate mux selects, and a single-cycle register write enable. It owns the program counter and replaces the free-running counter and instruction latch in front of the datapath. Illegal opcodes and fetch timeouts halt the sequencer.

## Interface
- RESET_PC, 32'h0, PC value loaded on reset
- PC_STEP, 4, PC increment per retired instruction
- FETCH_TIMEOUT, 15, maximum wait cycles in FETCH before a fault (1..255)
- clk  in  1  clock; all state updates on posedge
- reset  in  1  asynchronous, active-high; clears all state immediately
- start  in  1  level; leaves IDLE
- stop  in  1  one-cycle pulse; requests return to IDLE after the current instruction
- imem_addr  out  32  fetch address (= pc)
- imem_req  out  1  fetch request
- imem_ready  in  1  instruction valid this cycle
- imem_rdata  in  32  instruction word
- out1addr  out  3  regfile read port 1 (instr[2:0])
- out2addr  out  3  regfile read port 2 (instr[10:8])
- inaddr  out  3  regfile write address (instr[18:16])
- alu_select  out  3  instr[26:24]
- neg_sel  out  1  1 = two's-complement operand (SUB only)
- reg_sel  out  1  0 = immediate operand (LOADI), 1 = register operand
- imm_val  out  8  instr[7:0]
- reg_we  out  1  register write strobe
- busy  out  1  high in every state except IDLE and HALT
- halted  out  1  sticky HALT indication
- fault  out  2  00 none, 01 illegal opcode, 10 fetch timeout
- retired  out  16  retired-instruction count, wraps at 16'hFFFF -> 0

## Operation
- States: IDLE, FETCH, DECODE, EXEC, WB, HALT.
- Reset: state IDLE, pc=RESET_PC, ir=0, all control outputs 0, imem_req=0, reg_we=0, busy=0, halted=0, fault=00, retired=0, stop_pending=0.
- IDLE: if start=1, go to FETCH. A stop pulse in IDLE is ignored.
- FETCH: imem_req=1, imem_addr=pc.
  - imem_ready=1 on a posedge: ir<=imem_rdata, then DECODE.
  - Otherwise the wait counter increments. If ready has not arrived after FETCH_TIMEOUT waiting cycles: HALT, fault=10.
  - A ready arriving together with the timeout wins.
- DECODE: check ir[31:24].
  - Legal opcodes are 00, 01, 02, 03, 08 and 09. Any other value: HALT, fault=01, pc unchanged.
  - Legal: register control fields from ir, then EXEC.
- Control fields per opcode:
  - LOADI: reg_sel=0, neg_sel=0.
  - ADD, AND, OR, MOV: reg_sel=1, neg_sel=0.
  - SUB: reg_sel=1, neg_sel=1.
  - alu_select is always ir[26:24]. MOV therefore forwards and SUB adds.
- EXEC: one cycle for read-data and ALU settling; reg_we=0. Then WB.
- WB: reg_we=1 for exactly this cycle; pc<=pc+PC_STEP (32-bit wrap); retired<=retired+1.
  - If stop_pending or stop=1: go to IDLE and clear stop_pending.
  - Otherwise go to FETCH.
- stop in FETCH, DECODE or EXEC sets stop_pending. The in-flight instruction always completes WB.
- HALT: busy=0, halted=1, reg_we=0, imem_req=0. The state is left only by reset; start and stop are ignored.
- Control fields (addresses, selects, imm_val) stay stable from EXEC through WB and keep their last values in IDLE and FETCH.

## Timing
- Registered outputs only; no combinational path from inputs to outputs.
- Minimum instruction length is 4 cycles: FETCH with ready on the first cycle, then DECODE, EXEC, WB.
- Each wait cycle in FETCH adds one cycle.
- start sampled in IDLE gives imem_req=1 on the following cycle.
- imem_req drops in the cycle after ready is accepted.
- reg_we is high in cycle 4 of each instruction, counted from the first FETCH cycle.
- A new fetch begins on the cycle after WB.
- Asserting reset mid-instruction (any state) clears everything at once. No partial write occurs, because reg_we drops at once.
- stop and a WB in the same cycle: the sequencer goes to IDLE after that WB.

## Test plan
- **Reset values:** reset with imem_ready=1 and start=1 -> all outputs at reset values; after release, FETCH begins with imem_addr=0.
- **Back-to-back fetch:** program with instant ready: LOADI 4,0xFF; ADD 5,6,3; SUB 4,7,3 -> reg_we pulses at cycles 4, 8, 12; pc becomes 4, 8, 12; retired=3.
  - SUB decode gives neg_sel=1, reg_sel=1, alu_select=001, inaddr=4, out2addr=7, out1addr=3.
  - LOADI decode gives reg_sel=0, imm_val=0xFF.
- **Fetch wait:** ready withheld 5 cycles -> imem_req held for 6 cycles and imem_addr stable; no fault.
  - Ready withheld 15 cycles -> halted=1, fault=10, pc unchanged, retired unchanged.
- **Illegal opcode:** instruction 0x05xxxxxx -> HALT after DECODE, fault=01, reg_we never asserted, pc unchanged; a later start is ignored.
- **Stop and reset:** stop pulsed during EXEC -> WB completes (reg_we=1, retired+1), then IDLE with busy=0.
  - reset asserted during WB -> reg_we=0 immediately, pc=RESET_PC.

Source files
------------

// File: rtl/cpu_seq_ctrl.sv
// cpu_seq_ctrl: multi-cycle fetch/decode/execute sequencer for the 8-bit register/ALU datapath.
// Owns the program counter and instruction register, and halts on an illegal opcode or a fetch timeout.
module cpu_seq_ctrl #(
  parameter logic [31:0] RESET_PC      = 32'h0,
  parameter logic [31:0] PC_STEP       = 32'd4,
  parameter int unsigned FETCH_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [2:0]  out1addr,
  output logic [2:0]  out2addr,
  output logic [2:0]  inaddr,
  output logic [2:0]  alu_select,
  output logic        neg_sel,
  output logic        reg_sel,
  output logic [7:0]  imm_val,
  output logic        reg_we,
  output logic        busy,
  output logic        halted,
  output logic [1:0]  fault,
  output logic [15:0] retired
);
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT} state_t;
  localparam logic [7:0] WAIT_LAST = 8'(FETCH_TIMEOUT - 1);
  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, ir_q, ir_d;
  logic [7:0]  wait_q, wait_d, imm_q, imm_d;
  logic [15:0] retired_q, retired_d;
  logic [1:0]  fault_q, fault_d;
  logic [2:0]  o1_q, o1_d, o2_q, o2_d, in_q, in_d, alu_q, alu_d;
  logic        neg_q, neg_d, rsel_q, rsel_d, pend_q, pend_d;
  logic        req_q, we_q, busy_q, halt_q;
  logic [7:0]  op;
  logic        legal, ir_unused;
  assign op        = ir_q[31:24];
  assign legal     = op inside {8'h00, 8'h01, 8'h02, 8'h03, 8'h08, 8'h09};
  assign ir_unused = ^{ir_q[23:19], ir_q[15:11]};
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    wait_d    = wait_q;
    retired_d = retired_q;
    fault_d   = fault_q;
    pend_d    = pend_q;
    o1_d      = o1_q;
    o2_d      = o2_q;
    in_d      = in_q;
    alu_d     = alu_q;
    imm_d     = imm_q;
    neg_d     = neg_q;
    rsel_d    = rsel_q;
    case (state_q)
      S_IDLE: begin
        state_d = start ? S_FETCH : S_IDLE;
        wait_d  = 8'd0;
      end
      S_FETCH: begin
        pend_d = pend_q | stop;
        // a ready word is accepted even on the cycle the wait budget runs out
        if (imem_ready) begin
          ir_d    = imem_rdata;
          state_d = S_DECODE;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_HALT;
          fault_d = 2'b10;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_DECODE: begin
        pend_d = pend_q | stop;
        if (!legal) begin
          state_d = S_HALT;
          fault_d = 2'b01;
        end else begin
          state_d = S_EXEC;
          o1_d    = ir_q[2:0];
          o2_d    = ir_q[10:8];
          in_d    = ir_q[18:16];
          alu_d   = ir_q[26:24];
          imm_d   = ir_q[7:0];
          rsel_d  = op != 8'h00;
          neg_d   = op == 8'h09;
        end
      end
      S_EXEC: begin
        pend_d  = pend_q | stop;
        state_d = S_WB;
      end
      S_WB: begin
        pc_d      = pc_q + PC_STEP;
        retired_d = retired_q + 16'd1;
        state_d   = (stop | pend_q) ? S_IDLE : S_FETCH;
        pend_d    = 1'b0;
        wait_d    = 8'd0;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      wait_q    <= '0;
      retired_q <= '0;
      fault_q   <= '0;
      pend_q    <= 1'b0;
      o1_q      <= '0;
      o2_q      <= '0;
      in_q      <= '0;
      alu_q     <= '0;
      imm_q     <= '0;
      neg_q     <= 1'b0;
      rsel_q    <= 1'b0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      busy_q    <= 1'b0;
      halt_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
      fault_q   <= fault_d;
      pend_q    <= pend_d;
      o1_q      <= o1_d;
      o2_q      <= o2_d;
      in_q      <= in_d;
      alu_q     <= alu_d;
      imm_q     <= imm_d;
      neg_q     <= neg_d;
      rsel_q    <= rsel_d;
      req_q     <= state_d == S_FETCH;
      we_q      <= state_d == S_WB;
      busy_q    <= !(state_d inside {S_IDLE, S_HALT});
      halt_q    <= state_d == S_HALT;
    end
  end
  assign imem_addr  = pc_q;
  assign imem_req   = req_q;
  assign out1addr   = o1_q;
  assign out2addr   = o2_q;
  assign inaddr     = in_q;
  assign alu_select = alu_q;
  assign neg_sel    = neg_q;
  assign reg_sel    = rsel_q;
  assign imm_val    = imm_q;
  assign reg_we     = we_q;
  assign busy       = busy_q;
  assign halted     = halt_q;
  assign fault      = fault_q;
  assign retired    = retired_q;
endmodule
